// File: rtl/ssd_panel_streamer.sv
// SSD1306-style panel streamer: runs the power-up command list, streams the
// framebuffer page by page and polls a SPI keyboard between frames.
module ssd_panel_streamer #(
  parameter int WIDTH      = 128,
  parameter int PAGES      = 8,
  parameter int INIT_LEN   = 26,
  parameter int FINIT_LEN  = 6,
  parameter int KEY_BYTES  = 1,
  parameter int KEY_EVERY  = 1,
  parameter int CONTINUOUS = 1,
  parameter int NUM_CS     = 2,
  localparam int FRAME_LEN = WIDTH * PAGES,
  localparam int FB_AW     = $clog2(FRAME_LEN)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Frame_Start,
  output logic [7:0]        o_Cmd_Addr,
  input  logic [7:0]        i_Cmd_Byte,
  output logic [FB_AW-1:0]  o_Fb_Addr,
  input  logic [7:0]        i_Fb_Data,
  output logic [7:0]        o_TX_Byte,
  output logic              o_TX_DV,
  input  logic              i_TX_Ready,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_RES,
  output logic              o_DC,
  output logic [NUM_CS-1:0] o_CS_N,
  output logic [7:0]        o_Key_Event,
  output logic              o_Key_Valid,
  output logic              o_Frame_Done,
  output logic              o_Busy
);

  localparam int DISP_CS = 0;
  localparam int KEY_CS  = 1;

  typedef enum logic [2:0] {
    S_RESET, S_INIT, S_FINIT, S_STREAM, S_KEY, S_KEYUPD, S_NEXT, S_IDLE
  } state_t;

  state_t     state_q, state_d;
  logic       issue;
  logic [7:0] issue_byte;
  logic       master_free;
  logic       fb_changed;
  logic       stream_done;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_inc;
  logic [7:0] rx_last;
  logic [2:0] key_tx;
  logic [2:0] rx_cnt;

  assign o_RES         = ~i_Reset;
  assign frame_cnt_inc = frame_cnt + 8'd1;

  // A new byte may start only once the master is idle and the previous strobe
  // has been seen, so transitions (and CS/DC changes) also wait for this.
  assign master_free = i_TX_Ready & ~o_TX_DV;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_q <= S_RESET;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_byte = 8'h00;
    o_CS_N     = '1;
    o_DC       = 1'b0;
    o_Busy     = 1'b1;
    case (state_q)
      S_RESET: begin
        if (i_TX_Ready) state_d = S_INIT;
      end
      S_INIT: begin
        o_CS_N[DISP_CS] = 1'b0;
        if (master_free) begin
          if (o_Cmd_Addr != 8'(INIT_LEN)) begin
            issue      = 1'b1;
            issue_byte = i_Cmd_Byte;
          end else begin
            state_d = S_FINIT;
          end
        end
      end
      S_FINIT: begin
        o_CS_N[DISP_CS] = 1'b0;
        if (master_free) begin
          if (o_Cmd_Addr != 8'(INIT_LEN + FINIT_LEN)) begin
            issue      = 1'b1;
            issue_byte = i_Cmd_Byte;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        o_CS_N[DISP_CS] = 1'b0;
        o_DC            = 1'b1;
        if (master_free) begin
          if (!stream_done) begin
            if (!fb_changed) begin
              issue      = 1'b1;
              issue_byte = i_Fb_Data;
            end
          end else begin
            state_d = (frame_cnt == 8'd0) ? S_KEY : S_NEXT;
          end
        end
      end
      S_KEY: begin
        o_CS_N[KEY_CS] = 1'b0;
        o_DC           = 1'b1;
        if (i_RX_DV && rx_cnt == 3'(KEY_BYTES - 1)) begin
          state_d = S_KEYUPD;
        end else if (master_free && key_tx != 3'(KEY_BYTES)) begin
          issue = 1'b1;
        end
      end
      S_KEYUPD: state_d = S_NEXT;
      S_NEXT:   state_d = (CONTINUOUS != 0) ? S_FINIT : S_IDLE;
      S_IDLE: begin
        o_Busy = 1'b0;
        if (i_Frame_Start) state_d = S_FINIT;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Datapath: strobes, source addresses, frame counter and keyboard capture.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_TX_DV      <= 1'b0;
      o_TX_Byte    <= 8'h00;
      o_Cmd_Addr   <= 8'h00;
      o_Fb_Addr    <= '0;
      o_Key_Event  <= 8'hFF;
      o_Key_Valid  <= 1'b0;
      o_Frame_Done <= 1'b0;
      fb_changed   <= 1'b0;
      stream_done  <= 1'b0;
      frame_cnt    <= 8'd0;
      rx_last      <= 8'h00;
      key_tx       <= 3'd0;
      rx_cnt       <= 3'd0;
    end else begin
      o_TX_DV      <= issue;
      o_Key_Valid  <= 1'b0;
      o_Frame_Done <= 1'b0;
      fb_changed   <= 1'b0;
      if (issue) o_TX_Byte <= issue_byte;

      case (state_q)
        S_RESET: o_Cmd_Addr <= 8'h00;
        S_INIT: begin
          if (issue) o_Cmd_Addr <= o_Cmd_Addr + 8'd1;
        end
        S_FINIT: begin
          if (issue) o_Cmd_Addr <= o_Cmd_Addr + 8'd1;
          if (state_d == S_STREAM) begin
            o_Cmd_Addr  <= 8'(INIT_LEN);
            o_Fb_Addr   <= '0;
            stream_done <= 1'b0;
          end
        end
        S_STREAM: begin
          if (issue) begin
            fb_changed <= 1'b1;
            if (o_Fb_Addr == FB_AW'(FRAME_LEN - 1)) begin
              o_Fb_Addr    <= '0;
              stream_done  <= 1'b1;
              o_Frame_Done <= 1'b1;
              frame_cnt    <= (frame_cnt_inc == 8'(KEY_EVERY)) ? 8'd0 : frame_cnt_inc;
            end else begin
              o_Fb_Addr <= o_Fb_Addr + FB_AW'(1);
            end
          end
          if (state_d == S_KEY) begin
            key_tx <= 3'd0;
            rx_cnt <= 3'd0;
          end
        end
        S_KEY: begin
          if (issue) key_tx <= key_tx + 3'd1;
          if (i_RX_DV) begin
            rx_last <= i_RX_Byte;
            rx_cnt  <= rx_cnt + 3'd1;
          end
        end
        S_KEYUPD: begin
          if (rx_last != 8'h00) begin
            o_Key_Event <= rx_last;
            o_Key_Valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_panel_streamer.sv
// Directed bench: a byte-level SPI master model logs every transmitted byte
// with its CS_N/DC context; the main sequence checks the log against the ROM.
module tb_ssd_panel_streamer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       frameStart;
  logic [7:0] cmdAddr, cmdByte, fbData, txByte, rxByte, keyEvent;
  logic [9:0] fbAddr;
  logic       txDv, txReady, rxDv, res, dc, keyValid, frameDone, busy;
  logic [1:0] csN;
  logic       masterReady = 1'b1;
  logic       holdReady;

  int checks = 0;
  int errors = 0;

  logic [10:0] logData [0:4095];
  int logCount = 0;
  int busyCnt = 0;
  logic curIsKey = 1'b0;
  logic [7:0] misoTable [0:7];
  int misoIdx = 0;
  int cycle = 0;
  int lastKeyRxCycle = 0;
  int validCount = 0;
  int validCycle = 0;
  int doneCount = 0;
  int doneAtLog = 0;
  int snapLog;
  logic [9:0] snapFb;

  ssd_panel_streamer #(
    .WIDTH(128), .PAGES(8), .INIT_LEN(26), .FINIT_LEN(6),
    .KEY_BYTES(2), .KEY_EVERY(1), .CONTINUOUS(0), .NUM_CS(2)
  ) dut (
    .i_Clk(clock), .i_Reset(reset), .i_Frame_Start(frameStart),
    .o_Cmd_Addr(cmdAddr), .i_Cmd_Byte(cmdByte),
    .o_Fb_Addr(fbAddr), .i_Fb_Data(fbData),
    .o_TX_Byte(txByte), .o_TX_DV(txDv), .i_TX_Ready(txReady),
    .i_RX_DV(rxDv), .i_RX_Byte(rxByte),
    .o_RES(res), .o_DC(dc), .o_CS_N(csN),
    .o_Key_Event(keyEvent), .o_Key_Valid(keyValid),
    .o_Frame_Done(frameDone), .o_Busy(busy)
  );

  function automatic logic [7:0] romVal(input logic [7:0] a);
    return a * 8'd13 + 8'h5A;
  endfunction

  assign cmdByte = romVal(cmdAddr);
  assign txReady = masterReady & ~holdReady;

  always @(posedge clock) fbData <= fbAddr[7:0];

  // Master model: 8-cycle bytes, one RX strobe per byte, MISO only under KEY_CS.
  always @(posedge clock) begin
    #1;
    cycle = cycle + 1;
    rxDv = 1'b0;
    if (busyCnt > 0) begin
      busyCnt = busyCnt - 1;
      if (busyCnt == 0) begin
        masterReady = 1'b1;
        rxDv = 1'b1;
        if (curIsKey) begin
          rxByte = misoTable[misoIdx % 8];
          misoIdx = misoIdx + 1;
          lastKeyRxCycle = cycle;
        end else begin
          rxByte = 8'hEE;
        end
      end
    end
    if (txDv) begin
      if (logCount < 4096) logData[logCount] = {csN, dc, txByte};
      logCount = logCount + 1;
      masterReady = 1'b0;
      busyCnt = 8;
      curIsKey = (csN == 2'b01);
    end
    if (frameDone) begin
      doneCount = doneCount + 1;
      doneAtLog = logCount;
    end
    if (keyValid) begin
      validCount = validCount + 1;
      validCycle = cycle;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic rst, input logic start, input logic hold, input int n);
    reset      = rst;
    frameStart = start;
    holdReady  = hold;
    tick(n);
  endtask

  task automatic waitLog(input int n, input string tag);
    int budget = 30000;
    while (logCount < n && budget > 0) begin
      tick(1);
      budget--;
    end
    checkOutput(tag, 32'(logCount >= n), 32'd1);
  endtask

  task automatic checkRom(input int first, input int romFirst, input int count, input string tag);
    for (int i = 0; i < count; i++)
      checkOutput($sformatf("%s_%0d", tag, i), 32'(logData[first+i]),
                  32'({2'b10, 1'b0, romVal(8'(romFirst + i))}));
  endtask

  task automatic checkFrame(input int first, input int count, input string tag);
    for (int i = 0; i < count; i++)
      checkOutput($sformatf("%s_%0d", tag, i), 32'(logData[first+i]),
                  32'({2'b10, 1'b1, 8'(i)}));
  endtask

  initial begin
    misoTable[0] = 8'h00; misoTable[1] = 8'h00;
    misoTable[2] = 8'h00; misoTable[3] = 8'h41;
    for (int i = 4; i < 8; i++) misoTable[i] = 8'h00;
    rxByte = 8'h00;
    rxDv   = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("rst_csn", 32'(csN), 32'h3);
    checkOutput("rst_dc", 32'(dc), 32'h0);
    checkOutput("rst_txdv", 32'(txDv), 32'h0);
    checkOutput("rst_txbyte", 32'(txByte), 32'h0);
    checkOutput("rst_cmdaddr", 32'(cmdAddr), 32'h0);
    checkOutput("rst_fbaddr", 32'(fbAddr), 32'h0);
    checkOutput("rst_keyevent", 32'(keyEvent), 32'hFF);
    checkOutput("rst_keyvalid", 32'(keyValid), 32'h0);
    checkOutput("rst_framedone", 32'(frameDone), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);
    checkOutput("rst_res", 32'(res), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("res_released", 32'(res), 32'h1);
    checkOutput("dv_after_1", 32'(txDv), 32'h0);
    tick(1);
    checkOutput("dv_after_2", 32'(txDv), 32'h1);
    checkOutput("first_byte", 32'(txByte), 32'h5A);

    // Frame 1: init + finit, 1024 data bytes, keyboard poll returning zeros.
    waitLog(32, "wait_init");
    checkRom(0, 0, 32, "init");
    waitLog(1056, "wait_frame1");
    checkFrame(32, 1024, "frame1");
    tick(2);
    checkOutput("done_count1", 32'(doneCount), 32'd1);
    checkOutput("done_at1", 32'(doneAtLog), 32'd1056);
    waitLog(1058, "wait_key1");
    tick(20);
    checkOutput("key1_b0", 32'(logData[1056]), 32'h300);
    checkOutput("key1_b1", 32'(logData[1057]), 32'h300);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_csn", 32'(csN), 32'h3);
    checkOutput("zero_key_event", 32'(keyEvent), 32'hFF);
    checkOutput("zero_key_valid", 32'(validCount), 32'd0);
    checkOutput("idle_parked", 32'(logCount), 32'd1058);

    // Frame 2 on request, with a long Ready-low hold in the middle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    waitLog(1500, "wait_mid2");
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    snapLog = logCount;
    snapFb  = fbAddr;
    tick(40);
    checkOutput("hold_log", 32'(logCount), 32'(snapLog));
    checkOutput("hold_fb", 32'(fbAddr), 32'(snapFb));
    checkOutput("hold_dv", 32'(txDv), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    waitLog(2090, "wait_frame2");
    tick(20);
    checkRom(1058, 26, 6, "finit2");
    checkFrame(1064, 1024, "frame2");
    checkOutput("done_count2", 32'(doneCount), 32'd2);
    checkOutput("done_at2", 32'(doneAtLog), 32'd2088);
    checkOutput("key2_b0", 32'(logData[2088]), 32'h300);
    checkOutput("key2_b1", 32'(logData[2089]), 32'h300);
    checkOutput("key_event", 32'(keyEvent), 32'h41);
    checkOutput("key_valid_count", 32'(validCount), 32'd1);
    checkOutput("key_valid_latency", 32'(validCycle - lastKeyRxCycle), 32'd2);
    checkOutput("idle2_busy", 32'(busy), 32'h0);

    // Frame 3 interrupted by reset after 500 data bytes.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    waitLog(2596, "wait_byte500");
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("midrst_csn", 32'(csN), 32'h3);
    checkOutput("midrst_dv", 32'(txDv), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h1);
    checkOutput("midrst_fbaddr", 32'(fbAddr), 32'h0);
    checkOutput("midrst_cmdaddr", 32'(cmdAddr), 32'h0);
    checkOutput("midrst_keyevent", 32'(keyEvent), 32'hFF);
    checkOutput("midrst_logcount", 32'(logCount), 32'd2596);
    checkRom(2090, 26, 6, "finit3");
    checkFrame(2096, 500, "frame3");
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    waitLog(2628, "wait_reinit");
    checkRom(2596, 0, 32, "reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
